// File: rtl/fp_subtractor_seq.sv
// fp_subtractor_seq: iterative single-precision a - b with valid/ready on both sides
module fp_subtractor_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic                   overflow,
    output logic                   underflow
);
    localparam int M  = MAN_W + 2;
    localparam int CW = $clog2(M + 1);
    localparam logic [EXP_W-1:0] EMAX = '1;

    typedef enum logic [2:0] {IDLE, ALIGN, SUB, NORM, DONE} state_t;
    state_t state, state_nx;

    logic             sgn_f, sgn_s;
    logic [EXP_W-1:0] exp_r;
    logic [M-1:0]     man_f, man_s;
    logic [CW-1:0]    cnt;

    logic [EXP_W-1:0] ea, eb, diff;
    logic             a_first;
    logic [CW-1:0]    diff_sat;
    logic             carry, hid, mz, shl;

    assign ea       = a[EXP_W+MAN_W-1:MAN_W];
    assign eb       = b[EXP_W+MAN_W-1:MAN_W];
    assign a_first  = ea >= eb;
    assign diff     = a_first ? ea - eb : eb - ea;
    assign diff_sat = (diff > EXP_W'(M)) ? CW'(M) : CW'(diff);
    assign carry    = man_f[M-1];
    assign hid      = man_f[M-2];
    assign mz       = man_f == '0;
    assign shl      = !carry && !hid && !mz && exp_r != '0;
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // next-state: ALIGN is skipped when exponents already match
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (in_valid) state_nx = (diff_sat != '0) ? ALIGN : SUB;
            ALIGN:   if (cnt == CW'(1)) state_nx = SUB;
            SUB:     state_nx = NORM;
            NORM:    if (!shl) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // datapath: operand capture, alignment, magnitude add/sub, normalisation and packing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sgn_f     <= 1'b0;
            sgn_s     <= 1'b0;
            exp_r     <= '0;
            man_f     <= '0;
            man_s     <= '0;
            cnt       <= '0;
            result    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (in_valid) begin
                    sgn_f <= a_first ? a[EXP_W+MAN_W] : ~b[EXP_W+MAN_W];
                    sgn_s <= a_first ? ~b[EXP_W+MAN_W] : a[EXP_W+MAN_W];
                    exp_r <= a_first ? ea : eb;
                    man_f <= {2'b01, a_first ? a[MAN_W-1:0] : b[MAN_W-1:0]};
                    man_s <= {2'b01, a_first ? b[MAN_W-1:0] : a[MAN_W-1:0]};
                    cnt   <= diff_sat;
                end
                ALIGN: begin
                    man_s <= man_s >> 1;
                    cnt   <= cnt - 1'b1;
                end
                SUB: begin
                    if (sgn_f == sgn_s) man_f <= man_f + man_s;
                    else if (man_f >= man_s) man_f <= man_f - man_s;
                    else begin
                        man_f <= man_s - man_f;
                        sgn_f <= sgn_s;
                    end
                end
                NORM: begin
                    if (carry) begin
                        // incrementing into all-ones (or past it) saturates to {sign, FF, 0}
                        overflow  <= exp_r >= EMAX - 1'b1;
                        underflow <= 1'b0;
                        result    <= (exp_r >= EMAX - 1'b1) ? {sgn_f, EMAX, {MAN_W{1'b0}}}
                                                           : {sgn_f, exp_r + 1'b1, man_f[MAN_W:1]};
                    end else if (shl) begin
                        man_f <= man_f << 1;
                        exp_r <= exp_r - 1'b1;
                    end else if (mz || !hid) begin
                        result    <= '0;
                        overflow  <= 1'b0;
                        underflow <= 1'b1;
                    end else begin
                        result    <= {sgn_f, exp_r, man_f[MAN_W-1:0]};
                        overflow  <= exp_r == EMAX;
                        underflow <= exp_r == '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_subtractor_seq.sv
// tb_fp_subtractor_seq: scoreboard bench with an arithmetic reference model
module tb_fp_subtractor_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0, b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        overflow, underflow;

    fp_subtractor_seq dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   stall_req = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: signed integer sum of aligned significands, then renormalise.
    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
        exp_t   r;
        int     ex, ey, e, d, sh, norm;
        longint mx, my, mf, ms, v, mag;
        logic   sx, sy, sf, ss, s;
        ex = int'(x[30:23]); ey = int'(y[30:23]);
        mx = longint'({1'b1, x[22:0]}); my = longint'({1'b1, y[22:0]});
        sx = x[31]; sy = ~y[31];
        if (ex >= ey) begin e = ex; d = ex - ey; mf = mx; sf = sx; ms = my; ss = sy; end
        else          begin e = ey; d = ey - ex; mf = my; sf = sy; ms = mx; ss = sx; end
        sh = (d > 25) ? 25 : d;
        ms = ms >>> sh;
        v = (sf ? -mf : mf) + (ss ? -ms : ms);
        s = v < 0;
        mag = s ? -v : v;
        norm = 1;
        r.ovf = 1'b0; r.unf = 1'b0;
        if (mag >= (64'sd1 << 24)) begin
            if (e >= 254) begin r.res = {s, 8'hFF, 23'd0}; r.ovf = 1'b1; end
            else begin mag = mag >>> 1; r.res = {s, 8'(e + 1), mag[22:0]}; end
        end else begin
            while (mag != 0 && mag < (64'sd1 << 23) && e > 0) begin
                mag = mag <<< 1; e--; norm++;
            end
            if (mag == 0 || mag < (64'sd1 << 23)) begin r.res = 32'd0; r.unf = 1'b1; end
            else begin
                r.res = {s, 8'(e), mag[22:0]};
                r.ovf = e == 255;
                r.unf = e == 0;
            end
        end
        r.lat = 1 + sh + 1 + norm;
        r.acc = 0;
        return r;
    endfunction

    task automatic send(input logic [31:0] x, input logic [31:0] y, input bit push);
        int   t = 0;
        exp_t e;
        @(negedge clk);
        while (!in_ready && t < 300) begin @(negedge clk); t++; end
        if (!in_ready) begin
            chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
            return;
        end
        a = x; b = y; in_valid = 1'b1;
        if (push) begin
            e = model(x, y);
            e.acc = cyc;
            sb.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Monitor: compare each new result with the queue head, then hold out_ready per stall budget.
    bit          seen = 1'b0;
    int          stall = 0;
    logic [31:0] held;
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (!seen) begin
                if (sb.size() == 0) chk("unexpected_out", 32'd1, 32'd0);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("result", result, e.res);
                    chk("overflow", {31'd0, overflow}, {31'd0, e.ovf});
                    chk("underflow", {31'd0, underflow}, {31'd0, e.unf});
                    chk("latency", cyc - e.acc, e.lat);
                end
                seen = 1'b1;
                held = result;
                stall = (stall_req > 0) ? stall_req : int'($urandom_range(0, 2));
            end else chk("stable_result", result, held);
            chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
            out_ready = (stall == 0);
            if (stall > 0) stall--;
        end else begin
            seen = 1'b0;
            out_ready = 1'b0;
        end
    end

    initial begin
        int t;
        logic [31:0] x, y;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_flags", {30'd0, overflow, underflow}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        send(32'h40400000, 32'h3F800000, 1);
        send(32'h3F800000, 32'h3F800000, 1);
        send(32'h3F800000, 32'hBF800000, 1);
        send(32'h3F800000, 32'h30800000, 1);
        send(32'h7F000000, 32'hFF000000, 1);
        send(32'h3F800001, 32'h3F800000, 1);
        send(32'h00800000, 32'h00800001, 1);
        send(32'hBF800000, 32'h40000000, 1);

        for (int i = 0; i < 60; i++) begin
            x = $urandom;
            x[30:23] = 8'($urandom_range(0, 254));
            y = $urandom;
            y[30:23] = (i % 2 == 0) ? x[30:23] - 8'($urandom_range(0, 2)) : 8'($urandom_range(0, 254));
            if (y[30:23] == 8'hFF) y[30:23] = 8'h00;
            send(x, y, 1);
        end

        stall_req = 5;
        send(32'h40A00000, 32'h40000000, 1);
        t = 0;
        while (!out_valid && t < 100) begin @(negedge clk); t++; end
        stall_req = 0;
        t = 0;
        while (!in_ready && t < 100) begin @(negedge clk); t++; end
        chk("drain_stall", {31'd0, in_ready}, 32'd1);

        send(32'h3F800000, 32'h30800000, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midop_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midop_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midop_result", result, 32'd0);
        chk("midop_flags", {30'd0, overflow, underflow}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        send(32'h40400000, 32'h3F800000, 1);

        t = 0;
        while ((sb.size() != 0 || out_valid) && t < 300) begin @(negedge clk); t++; end
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
